// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, sequencer state encoding and default widths.
package alu_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;

    localparam logic [1:0] FLAG_N = 2'd3;
    localparam logic [1:0] FLAG_Z = 2'd2;
    localparam logic [1:0] FLAG_C = 2'd1;
    localparam logic [1:0] FLAG_V = 2'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/lsr_sequencer_lsr.sv
// Step-limited logical shift-right unit: shifts by at most 2^STEP_W-1 positions in one pass.
module lsr_sequencer_lsr #(
    parameter int unsigned STEP_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [STEP_W-1:0] i_amt,
    input  logic              i_s,
    output logic [DATA_W-1:0] o_result,
    output logic              o_c
);

    localparam int unsigned IDX_W = $clog2(DATA_W);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_result = i_data >> i_amt;
        w_idx    = IDX_W'(i_amt) - IDX_W'(1);
        // Carry is the last bit shifted out; only produced when flag setting is requested.
        o_c      = (i_s && (i_amt != '0)) ? i_data[w_idx] : 1'b0;
    end

endmodule

// File: rtl/lsr_sequencer.sv
// Multi-cycle logical shift-right controller: iterates the step-limited shifter and owns the
// architectural [N,Z,C,V] flag register.
module lsr_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned AMT_W  = 6,
    parameter int unsigned STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [DATA_W-1:0] In1,
    input  logic [AMT_W-1:0]  Amt,
    input  logic              S,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [DATA_W-1:0] Result,
    output logic [3:0]        New_Flag,
    output logic              Busy
);

    localparam int unsigned STEP_MAX = (2 ** STEP_W) - 1;
    localparam int unsigned IDX_W    = $clog2(DATA_W);

    state_e            r_state;
    logic [DATA_W-1:0] r_acc;
    logic [AMT_W-1:0]  r_rem;
    logic              r_s;
    logic              r_c_tmp;
    logic [3:0]        r_flags;

    logic [STEP_W-1:0] w_step;
    logic [AMT_W-1:0]  w_rem_next;
    logic [IDX_W-1:0]  w_idx;
    logic              w_c_next;
    logic [DATA_W-1:0] w_shift;
    logic              w_unused_lsr_c;

    always_comb begin
        w_step     = (r_rem > AMT_W'(STEP_MAX)) ? STEP_W'(STEP_MAX) : r_rem[STEP_W-1:0];
        w_rem_next = r_rem - AMT_W'(w_step);
        w_idx      = IDX_W'(w_step) - IDX_W'(1);
        w_c_next   = r_acc[w_idx];
    end

    // Flag generation stays in the controller, so the shifter's own S input is tied low.
    lsr_sequencer_lsr #(
        .STEP_W (STEP_W),
        .DATA_W (DATA_W)
    ) u_lsr (
        .i_data   (r_acc),
        .i_amt    (w_step),
        .i_s      (1'b0),
        .o_result (w_shift),
        .o_c      (w_unused_lsr_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_s     <= 1'b0;
            r_c_tmp <= 1'b0;
            r_flags <= 4'b0000;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (In_valid) begin
                        r_acc   <= In1;
                        r_rem   <= Amt;
                        r_s     <= S;
                        r_c_tmp <= r_flags[FLAG_C];
                        if (Amt == '0) begin
                            r_state <= DONE;
                            // Zero-length shift: C is kept, N and Z follow the operand.
                            if (S) begin
                                r_flags[FLAG_N] <= In1[DATA_W-1];
                                r_flags[FLAG_Z] <= (In1 == '0);
                            end
                        end else begin
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_acc   <= w_shift;
                    r_c_tmp <= w_c_next;
                    r_rem   <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_state <= DONE;
                        if (r_s) begin
                            r_flags[FLAG_N] <= w_shift[DATA_W-1];
                            r_flags[FLAG_Z] <= (w_shift == '0);
                            r_flags[FLAG_C] <= w_c_next;
                        end
                    end
                end
                DONE: begin
                    if (Out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign In_ready  = (r_state == IDLE);
    assign Out_valid = (r_state == DONE);
    assign Busy      = (r_state != IDLE);
    assign Result    = r_acc;
    assign New_Flag  = r_flags;

endmodule

// File: tb/tb_lsr_sequencer.sv
// Scoreboard bench for lsr_sequencer: driver pushes model results, monitor pops on Out_valid.
module tb_lsr_sequencer;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 6;
    localparam int unsigned SMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          In_valid = 1'b0;
    logic          In_ready;
    logic [DW-1:0] In1 = '0;
    logic [AW-1:0] Amt = '0;
    logic          S = 1'b0;
    logic          Out_valid;
    logic          Out_ready;
    logic [DW-1:0] Result;
    logic [3:0]    New_Flag;
    logic          Busy;

    lsr_sequencer #(
        .DATA_W (DW),
        .AMT_W  (AW),
        .STEP_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .In1       (In1),
        .Amt       (Amt),
        .S         (S),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Result    (Result),
        .New_Flag  (New_Flag),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] res;
        logic [3:0]    flg;
        int unsigned   vcyc;
    } exp_t;

    exp_t       q[$];
    logic [3:0] m_flags = 4'b0000;
    int         checks = 0;
    int         errors = 0;
    int         hold_req = 0;
    bit         active = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: LSR by amt with zero fill; C is the last bit shifted out (kept for amt=0).
    task automatic push_exp(input logic [DW-1:0] in1, input int amt, input bit s,
                            input int unsigned acc_cyc);
        exp_t e;
        logic c;
        int   n;
        e.res = (amt >= int'(DW)) ? '0 : (in1 >> amt);
        if (amt == 0)           c = m_flags[1];
        else if (amt > int'(DW)) c = 1'b0;
        else                    c = in1[amt-1];
        if (s) m_flags = {e.res[DW-1], (e.res == '0), c, m_flags[0]};
        n      = (amt + int'(SMAX) - 1) / int'(SMAX);
        e.flg  = m_flags;
        e.vcyc = acc_cyc + 1 + n;
        q.push_back(e);
    endtask

    task automatic send(input logic [DW-1:0] in1, input logic [AW-1:0] amt, input bit s,
                        input bit track);
        int w = 0;
        @(negedge clk);
        while (!In_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!In_ready) begin
            $display("FAIL send_timeout In_ready=%0b required=1", In_ready);
            errors++;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "stuck");
        end
        In1      = in1;
        Amt      = amt;
        S        = s;
        In_valid = 1'b1;
        if (track) push_exp(in1, int'(amt), s, cyc);
        @(posedge clk);
        #1;
        In_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((q.size() != 0 || active) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", {63'd0, (q.size() != 0 || active)}, 64'd0);
    endtask

    // Monitor: pops on the first Out_valid cycle, then checks stability while held.
    initial begin
        exp_t cur;
        int   hold_left = 0;
        bit   hs_pend = 0;
        Out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active    = 0;
                hs_pend   = 0;
                Out_ready = 1'b0;
                continue;
            end
            if (hs_pend) begin
                chk("in_ready_after_hs", {63'd0, In_ready}, 64'd1);
                chk("valid_drop_after_hs", {63'd0, Out_valid}, 64'd0);
                hs_pend = 0;
            end
            if (Out_valid) begin
                if (!active) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out actual=%0h required=none", Result);
                        cur.res = Result;
                        cur.flg = New_Flag;
                    end else begin
                        cur = q.pop_front();
                        chk("result", {32'd0, Result}, {32'd0, cur.res});
                        chk("new_flag", {60'd0, New_Flag}, {60'd0, cur.flg});
                        chk("latency", {32'd0, cyc}, {32'd0, cur.vcyc});
                    end
                    active    = 1;
                    hold_left = hold_req;
                    hold_req  = 0;
                end else begin
                    chk("hold_result", {32'd0, Result}, {32'd0, cur.res});
                    chk("hold_flag", {60'd0, New_Flag}, {60'd0, cur.flg});
                end
                chk("in_ready_in_done", {63'd0, In_ready}, 64'd0);
                if (hold_left > 0) begin
                    Out_ready = 1'b0;
                    hold_left--;
                end else begin
                    Out_ready = (($urandom % 4) != 0);
                end
                if (Out_ready) begin
                    active  = 0;
                    hs_pend = 1;
                end
            end else begin
                Out_ready = $urandom % 2;
            end
        end
    end

    initial begin
        int w;
        #1;
        chk("rst_in_ready", {63'd0, In_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, Out_valid}, 64'd0);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_result", {32'd0, Result}, 64'd0);
        chk("rst_flag", {60'd0, New_Flag}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        send(32'd3, 6'd1, 1'b1, 1'b1);
        send(32'hFFFF_FFFF, 6'd9, 1'b1, 1'b1);
        send(32'h8000_0000, 6'd32, 1'b1, 1'b1);
        send(32'h1234_5678, 6'd40, 1'b1, 1'b1);
        send(32'd3, 6'd1, 1'b1, 1'b1);
        send(32'hFFFF_FFFA, 6'd4, 1'b0, 1'b1);
        send(32'd0, 6'd0, 1'b1, 1'b1);
        send(32'hFFFF_FFFF, 6'd63, 1'b1, 1'b1);
        send(32'h8000_0001, 6'd15, 1'b1, 1'b1);
        drain();

        // Backpressure with a stray request presented while the result is held.
        hold_req = 5;
        send(32'hA5A5_0F0F, 6'd20, 1'b1, 1'b1);
        w = 0;
        while (!Out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("bp_valid_seen", {63'd0, Out_valid}, 64'd1);
        In1      = 32'hDEAD_BEEF;
        Amt      = 6'd7;
        S        = 1'b1;
        In_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", {63'd0, In_ready}, 64'd0);
        end
        In_valid = 1'b0;
        drain();

        // Asynchronous reset in the middle of a long shift.
        send(32'hCAFE_F00D, 6'd63, 1'b1, 1'b0);
        @(negedge clk);
        chk("mid_shift_busy", {63'd0, Busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {63'd0, In_ready}, 64'd1);
        chk("arst_out_valid", {63'd0, Out_valid}, 64'd0);
        chk("arst_result", {32'd0, Result}, 64'd0);
        chk("arst_flag", {60'd0, New_Flag}, 64'd0);
        m_flags = 4'b0000;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(32'd16, 6'd4, 1'b1, 1'b1);
        drain();

        for (int i = 0; i < 150; i++) begin
            logic [DW-1:0] d;
            case ($urandom % 4)
                0:       d = 32'hFFFF_FFFF;
                1:       d = 32'h8000_0000 >> ($urandom % 32);
                default: d = $urandom;
            endcase
            send(d, AW'($urandom_range(0, 63)), bit'($urandom % 2), 1'b1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
